// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: drives GO/STALL/FLUSH per pipeline register and the PC write enable.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall-cycle and redirect counters.
`ifndef GO
`define GO    2'b00
`endif
`ifndef STALL
`define STALL 2'b01
`endif
`ifndef FLUSH
`define FLUSH 2'b10
`endif

module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memRd_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             take_ex,
  input  logic             mul_start_ex,
  input  logic             dmem_busy,
  output logic             pc_wr,
  output logic [1:0]       ctrl_if_id,
  output logic [1:0]       ctrl_id_ex,
  output logic [1:0]       ctrl_ex_mem,
  output logic [1:0]       ctrl_mem_wb,
  output logic             mul_busy,
  output logic             stall_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
`endif
);

  typedef enum logic [0:0] {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;

  localparam bit             MUL_EN   = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] MUL_INIT = MUL_EN ? CNT_W'(MUL_LAT - 2) : CNT_W'(1'b0);

  state_t           state_r, state_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic             mul_done_r, mul_done_next;
  logic             load_use;
  logic             redirect;

  assign load_use = memRd_ex && (rd_ex != 5'd0) &&
                    ((use_rs_id && (rs_id == rd_ex)) || (use_rt_id && (rt_id == rd_ex)));

  // Priority decode: reset, memory wait, multiply occupancy, redirect, load-use.
  always_comb begin
    state_next    = state_r;
    cnt_next      = cnt_r;
    mul_done_next = mul_done_r;
    redirect      = 1'b0;
    pc_wr         = 1'b1;
    ctrl_if_id    = `GO;
    ctrl_id_ex    = `GO;
    ctrl_ex_mem   = `GO;
    ctrl_mem_wb   = `GO;
    if (rst) begin
      pc_wr       = 1'b0;
      ctrl_if_id  = `FLUSH;
      ctrl_id_ex  = `FLUSH;
      ctrl_ex_mem = `FLUSH;
      ctrl_mem_wb = `FLUSH;
    end else if (dmem_busy) begin
      // MEM/WB gets a bubble so the held MEM instruction is not written back twice.
      pc_wr       = 1'b0;
      ctrl_if_id  = `STALL;
      ctrl_id_ex  = `STALL;
      ctrl_ex_mem = `STALL;
      ctrl_mem_wb = `FLUSH;
    end else begin
      mul_done_next = 1'b0;
      case (state_r)
        MUL_BUSY: begin
          pc_wr       = 1'b0;
          ctrl_if_id  = `STALL;
          ctrl_id_ex  = `STALL;
          ctrl_ex_mem = `STALL;
          cnt_next    = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_next    = RUN;
            mul_done_next = 1'b1;
          end else begin
            state_next    = MUL_BUSY;
          end
        end
        RUN: begin
          if (MUL_EN && mul_start_ex && !mul_done_r) begin
            pc_wr       = 1'b0;
            ctrl_if_id  = `STALL;
            ctrl_id_ex  = `STALL;
            ctrl_ex_mem = `STALL;
            if (MUL_INIT == CNT_ZERO) begin
              mul_done_next = 1'b1;
            end else begin
              state_next = MUL_BUSY;
              cnt_next   = MUL_INIT;
            end
          end else if (take_ex) begin
            redirect   = 1'b1;
            ctrl_if_id = `FLUSH;
            ctrl_id_ex = `FLUSH;
          end else if (load_use) begin
            pc_wr      = 1'b0;
            ctrl_if_id = `STALL;
            ctrl_id_ex = `FLUSH;
          end else begin
            pc_wr      = 1'b1;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = CNT_ZERO;
        end
      endcase
    end
  end

  assign mul_busy = (state_r == MUL_BUSY) && !rst;
  assign stall_o  = ~pc_wr;

  // FSM, countdown and release flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      cnt_r      <= CNT_ZERO;
      mul_done_r <= 1'b0;
    end else begin
      state_r    <= state_next;
      cnt_r      <= cnt_next;
      mul_done_r <= mul_done_next;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!pc_wr && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect && (flush_events != 32'hFFFF_FFFF)) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a monitor compares.
`ifndef GO
`define GO    2'b00
`endif
`ifndef STALL
`define STALL 2'b01
`endif
`ifndef FLUSH
`define FLUSH 2'b10
`endif

module tb_pipe_hazard_ctrl;

  localparam logic [1:0] G = `GO;
  localparam logic [1:0] S = `STALL;
  localparam logic [1:0] F = `FLUSH;

  logic       clk = 1'b0;
  logic       rst;
  logic       memRd_ex;
  logic [4:0] rd_ex, rs_id, rt_id;
  logic       use_rs_id, use_rt_id, take_ex, mul_start_ex, dmem_busy;
  logic       pc_wr, mul_busy, stall_o;
  logic [1:0] ctrl_if_id, ctrl_id_ex, ctrl_ex_mem, ctrl_mem_wb;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .memRd_ex(memRd_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .take_ex(take_ex),
    .mul_start_ex(mul_start_ex), .dmem_busy(dmem_busy), .pc_wr(pc_wr),
    .ctrl_if_id(ctrl_if_id), .ctrl_id_ex(ctrl_id_ex), .ctrl_ex_mem(ctrl_ex_mem),
    .ctrl_mem_wb(ctrl_mem_wb), .mul_busy(mul_busy), .stall_o(stall_o)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      logic [10:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pc_wr, ctrl_if_id, ctrl_id_ex, ctrl_ex_mem, ctrl_mem_wb, mul_busy, stall_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got {pc,ifid,idex,exmem,memwb,mb,st}=%b want %b", n, a, e);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic memrd, input logic [4:0] rd,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                      input logic take, input logic mul, input logic busy,
                      input logic e_pc, input logic [1:0] e_ifid, input logic [1:0] e_idex,
                      input logic [1:0] e_exmem, input logic [1:0] e_memwb, input logic e_mb);
    @(posedge clk);
    #1;
    rst = r; memRd_ex = memrd; rd_ex = rd; rs_id = rs; rt_id = rt;
    use_rs_id = urs; use_rt_id = urt; take_ex = take; mul_start_ex = mul; dmem_busy = busy;
    exp_q.push_back({e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_mb, ~e_pc});
    name_q.push_back(nm);
  endtask

  initial begin
    rst = 1'b1; memRd_ex = 1'b0; rd_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    use_rs_id = 1'b0; use_rt_id = 1'b0; take_ex = 1'b0; mul_start_ex = 1'b1; dmem_busy = 1'b0;

    //   name            rst mrd rd    rs    rt    urs  urt  take mul  busy  pc   ifid idex exm memwb mb
    step("reset0",       1,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   F,   F,   F,  F,    0);
    step("reset1",       1,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   F,   F,   F,  F,    0);
    step("post_reset",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    step("lu_rs",        0,  1, 5'd5, 5'd5, 5'd0, 1,   0,   0,   0,   0,    0,   S,   F,   G,  G,    0);
    step("lu_after",     0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    step("lu_r0",        0,  1, 5'd0, 5'd0, 5'd0, 1,   1,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    step("lu_rt",        0,  1, 5'd7, 5'd1, 5'd7, 0,   1,   0,   0,   0,    0,   S,   F,   G,  G,    0);
    step("lu_rs_unused", 0,  1, 5'd7, 5'd7, 5'd3, 0,   1,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    step("branch",       0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   1,   0,   0,    1,   F,   F,   G,  G,    0);
    step("branch_lu",    0,  1, 5'd5, 5'd5, 5'd0, 1,   0,   1,   0,   0,    1,   F,   F,   G,  G,    0);
    step("busy_branch",  0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   1,   0,   1,    0,   S,   S,   S,  F,    0);
    // multiply, MUL_LAT=4, start held four cycles
    step("mul_start",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   S,   S,   S,  G,    0);
    step("mul_busy1",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   S,   S,   S,  G,    1);
    step("mul_busy2",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   1,   1,   0,    0,   S,   S,   S,  G,    1);
    step("mul_release",  0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    1,   G,   G,   G,  G,    0);
    step("mul_idle",     0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    // memory wait in MUL_BUSY with cnt=2
    step("mulb_start",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   S,   S,   S,  G,    0);
    step("mulb_wait0",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   1,    0,   S,   S,   S,  F,    1);
    step("mulb_wait1",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   1,    0,   S,   S,   S,  F,    1);
    step("mulb_wait2",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   1,    0,   S,   S,   S,  F,    1);
    step("mulb_cnt2",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   S,   S,   S,  G,    1);
    step("mulb_cnt1",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   S,   S,   S,  G,    1);
    // mul_done survives a memory wait, so the held start is still ignored afterwards
    step("done_wait",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   1,    0,   S,   S,   S,  F,    0);
    step("done_release", 0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    1,   G,   G,   G,  G,    0);
    step("done_idle",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    // reset mid-multiply abandons the countdown
    step("mulc_start",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   S,   S,   S,  G,    0);
    step("mulc_busy",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   S,   S,   S,  G,    1);
    step("mulc_reset",   1,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   1,   0,    0,   F,   F,   F,  F,    0);
    step("mulc_after",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    1,   G,   G,   G,  G,    0);
`ifdef PIPE_PERF_CNT_EN
    step("perf_reset",   1,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    0,   F,   F,   F,  F,    0);
    step("perf_br0",     0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   1,   0,   0,    1,   F,   F,   G,  G,    0);
    step("perf_lu",      0,  1, 5'd9, 5'd9, 5'd0, 1,   0,   0,   0,   0,    0,   S,   F,   G,  G,    0);
    step("perf_br1",     0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   1,   0,   0,    1,   F,   F,   G,  G,    0);
    step("perf_idle",    0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    @(negedge clk);
    #1;
    checks++;
    if (flush_events !== 32'd2) begin
      failures++;
      $display("FAIL perf_flush_events: got %0d want 2", flush_events);
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      failures++;
      $display("FAIL perf_stall_cycles: got %0d want 1", stall_cycles);
    end
`endif
    step("final_idle",   0,  0, 5'd0, 5'd0, 5'd0, 0,   0,   0,   0,   0,    1,   G,   G,   G,  G,    0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
